// File: rtl/uart_alu_interface.sv
// Gathers three UART bytes into an ALU command (A, B, opcode), forwards the ALU
// result to the transmitter as a one-cycle start pulse, and drops partial commands on timeout.
module uart_alu_interface #(
  parameter int IO_SIZE  = 8,
  parameter int OP_SIZE  = 6,
  parameter int TIMEOUT  = 1000000,
  parameter int TO_WIDTH = 20
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_rx_done,
  input  logic [IO_SIZE-1:0] i_rx_data,
  input  logic [IO_SIZE-1:0] i_alu_result,
  input  logic               i_tx_done,
  output logic [IO_SIZE-1:0] o_data_a,
  output logic [IO_SIZE-1:0] o_data_b,
  output logic [OP_SIZE-1:0] o_op,
  output logic [IO_SIZE-1:0] o_tx_data,
  output logic               o_tx_start,
  output logic               o_busy,
  output logic               o_timeout
);

  typedef enum logic [2:0] {
    WAIT_A  = 3'd0,
    WAIT_B  = 3'd1,
    WAIT_OP = 3'd2,
    SEND    = 3'd3,
    WAIT_TX = 3'd4
  } state_t;

  localparam bit                  TO_EN   = (TIMEOUT > 0);
  localparam logic [TO_WIDTH-1:0] TO_LAST = TO_WIDTH'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  state_t              state, state_nxt;
  logic [TO_WIDTH-1:0] to_cnt;
  logic                to_hit, to_fire, cnt_run;
  logic                ld_a, ld_b, ld_op, ld_tx;

  assign to_hit = TO_EN && (to_cnt == TO_LAST);
  assign o_busy = (state == SEND) || (state == WAIT_TX);

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) state <= WAIT_A;
    else         state <= state_nxt;
  end

  // A byte arriving on the terminal timeout cycle takes priority over the timeout.
  always_comb begin
    state_nxt = state;
    ld_a      = 1'b0;
    ld_b      = 1'b0;
    ld_op     = 1'b0;
    ld_tx     = 1'b0;
    to_fire   = 1'b0;
    cnt_run   = 1'b0;
    case (state)
      WAIT_A: if (i_rx_done) begin
        ld_a      = 1'b1;
        state_nxt = WAIT_B;
      end
      WAIT_B: begin
        cnt_run = 1'b1;
        if (i_rx_done) begin
          ld_b      = 1'b1;
          state_nxt = WAIT_OP;
        end else if (to_hit) begin
          to_fire   = 1'b1;
          state_nxt = WAIT_A;
        end
      end
      WAIT_OP: begin
        cnt_run = 1'b1;
        if (i_rx_done) begin
          ld_op     = 1'b1;
          state_nxt = SEND;
        end else if (to_hit) begin
          to_fire   = 1'b1;
          state_nxt = WAIT_A;
        end
      end
      SEND: begin
        ld_tx     = 1'b1;
        state_nxt = WAIT_TX;
      end
      WAIT_TX: if (i_tx_done) state_nxt = WAIT_A;
      default: state_nxt = WAIT_A;
    endcase
  end

  // Counter idles at zero outside WAIT_B/WAIT_OP, so entry into those states starts from 0.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset)                             to_cnt <= '0;
    else if (!cnt_run || i_rx_done || to_fire) to_cnt <= '0;
    else                                     to_cnt <= to_cnt + 1'b1;
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      o_data_a   <= '0;
      o_data_b   <= '0;
      o_op       <= '0;
      o_tx_data  <= '0;
      o_tx_start <= 1'b0;
      o_timeout  <= 1'b0;
    end else begin
      if (ld_a)  o_data_a  <= i_rx_data;
      if (ld_b)  o_data_b  <= i_rx_data;
      if (ld_op) o_op      <= i_rx_data[OP_SIZE-1:0];
      if (ld_tx) o_tx_data <= i_alu_result;
      o_tx_start <= ld_tx;
      o_timeout  <= to_fire;
    end
  end

endmodule

// File: tb/tb_uart_alu_interface.sv
// Directed bench for uart_alu_interface with an A+B ALU stub and TIMEOUT=100.
module tb_uart_alu_interface;
  logic       i_clk = 1'b0;
  logic       i_reset, i_rx_done, i_tx_done;
  logic [7:0] i_rx_data, i_alu_result;
  logic [7:0] o_data_a, o_data_b, o_tx_data;
  logic [5:0] o_op;
  logic       o_tx_start, o_busy, o_timeout;

  int errors = 0;
  int checks = 0;
  int start_cnt = 0;
  int to_cnt = 0;
  int dbl_cnt = 0;
  logic prev_start = 1'b0, prev_to = 1'b0;

  uart_alu_interface #(.IO_SIZE(8), .OP_SIZE(6), .TIMEOUT(100), .TO_WIDTH(20)) dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_rx_done(i_rx_done), .i_rx_data(i_rx_data),
    .i_alu_result(i_alu_result), .i_tx_done(i_tx_done), .o_data_a(o_data_a),
    .o_data_b(o_data_b), .o_op(o_op), .o_tx_data(o_tx_data), .o_tx_start(o_tx_start),
    .o_busy(o_busy), .o_timeout(o_timeout)
  );

  always #5 i_clk = ~i_clk;

  // ALU stub: A + B, wrapping at 8 bits
  assign i_alu_result = o_data_a + o_data_b;

  always @(negedge i_clk) begin
    if (o_tx_start) start_cnt++;
    if (o_timeout) to_cnt++;
    if ((o_tx_start && prev_start) || (o_timeout && prev_to)) dbl_cnt++;
    prev_start = o_tx_start;
    prev_to    = o_timeout;
  end

  // Called at a negedge; byte is sampled on the following posedge, returns at the next negedge.
  task automatic send_byte(input logic [7:0] b);
    i_rx_done = 1'b1;
    i_rx_data = b;
    @(negedge i_clk);
    i_rx_done = 1'b0;
  endtask

  task automatic pulse_tx_done();
    i_tx_done = 1'b1;
    @(negedge i_clk);
    i_tx_done = 1'b0;
  endtask

  task automatic test_reset();
    i_reset = 1'b1; i_rx_done = 1'b0; i_rx_data = 8'h00; i_tx_done = 1'b0;
    @(negedge i_clk);
    @(negedge i_clk);
    checks++;
    if ({o_data_a, o_data_b, o_op, o_tx_data, o_tx_start, o_busy, o_timeout} !== 35'd0) begin
      errors++;
      $display("FAIL reset_outputs: got a=%h b=%h op=%h tx=%h st=%b busy=%b to=%b, want all 0",
               o_data_a, o_data_b, o_op, o_tx_data, o_tx_start, o_busy, o_timeout);
    end
    i_reset = 1'b0;
    @(negedge i_clk);
  endtask

  task automatic test_basic();
    int s0;
    s0 = start_cnt;
    send_byte(8'h05);
    send_byte(8'h03);
    send_byte(8'h20);
    // after opcode edge N: registers loaded, start not yet
    checks++;
    if ({o_data_a, o_data_b, o_op} !== {8'h05, 8'h03, 6'h20}) begin
      errors++;
      $display("FAIL basic_regs: got a=%h b=%h op=%h, want 05 03 20", o_data_a, o_data_b, o_op);
    end
    checks++;
    if (o_tx_start !== 1'b0 || o_busy !== 1'b1) begin
      errors++;
      $display("FAIL basic_send_state: got st=%b busy=%b, want 0 1", o_tx_start, o_busy);
    end
    @(negedge i_clk);
    checks++;
    if (o_tx_start !== 1'b1 || o_tx_data !== 8'h08) begin
      errors++;
      $display("FAIL basic_start: got st=%b tx=%h, want 1 08", o_tx_start, o_tx_data);
    end
    @(negedge i_clk);
    checks++;
    if (o_tx_start !== 1'b0 || o_busy !== 1'b1) begin
      errors++;
      $display("FAIL basic_wait_tx: got st=%b busy=%b, want 0 1", o_tx_start, o_busy);
    end
    checks++;
    if (start_cnt - s0 !== 1) begin
      errors++;
      $display("FAIL basic_pulse_count: got %0d, want 1", start_cnt - s0);
    end
  endtask

  task automatic test_drop_in_wait_tx();
    send_byte(8'h11);
    checks++;
    if (o_data_a !== 8'h05 || o_busy !== 1'b1) begin
      errors++;
      $display("FAIL drop_byte: got a=%h busy=%b, want 05 1", o_data_a, o_busy);
    end
    pulse_tx_done();
    checks++;
    if (o_busy !== 1'b0 || o_data_a !== 8'h05) begin
      errors++;
      $display("FAIL drop_return: got busy=%b a=%h, want 0 05", o_busy, o_data_a);
    end
    send_byte(8'hFF);
    send_byte(8'h01);
    send_byte(8'h20);
    @(negedge i_clk);
    checks++;
    if (o_tx_start !== 1'b1 || o_tx_data !== 8'h00 || o_data_a !== 8'hFF) begin
      errors++;
      $display("FAIL wrap_result: got st=%b tx=%h a=%h, want 1 00 ff", o_tx_start, o_tx_data, o_data_a);
    end
    @(negedge i_clk);
    pulse_tx_done();
  endtask

  task automatic test_timeout();
    int t0;
    t0 = to_cnt;
    send_byte(8'h07);
    repeat (99) @(negedge i_clk);
    checks++;
    if (o_timeout !== 1'b0) begin
      errors++;
      $display("FAIL timeout_early: got to=%b after 99 idle cycles, want 0", o_timeout);
    end
    @(negedge i_clk);
    checks++;
    if (o_timeout !== 1'b1) begin
      errors++;
      $display("FAIL timeout_fire: got to=%b after 100 idle cycles, want 1", o_timeout);
    end
    @(negedge i_clk);
    checks++;
    if (o_timeout !== 1'b0 || to_cnt - t0 !== 1) begin
      errors++;
      $display("FAIL timeout_pulse: got to=%b count=%0d, want 0 1", o_timeout, to_cnt - t0);
    end
    send_byte(8'h09);
    send_byte(8'h02);
    send_byte(8'h20);
    @(negedge i_clk);
    checks++;
    if (o_tx_start !== 1'b1 || o_tx_data !== 8'h0B || o_data_a !== 8'h09 || o_data_b !== 8'h02) begin
      errors++;
      $display("FAIL timeout_resync: got st=%b tx=%h a=%h b=%h, want 1 0b 09 02",
               o_tx_start, o_tx_data, o_data_a, o_data_b);
    end
    @(negedge i_clk);
    pulse_tx_done();
  endtask

  task automatic test_timeout_boundary();
    int t0;
    t0 = to_cnt;
    send_byte(8'h04);
    repeat (99) @(negedge i_clk);
    send_byte(8'h06);           // sampled on the counter==99 edge
    checks++;
    if (o_timeout !== 1'b0 || o_data_b !== 8'h06) begin
      errors++;
      $display("FAIL boundary_accept: got to=%b b=%h, want 0 06", o_timeout, o_data_b);
    end
    send_byte(8'h20);
    @(negedge i_clk);
    checks++;
    if (o_tx_start !== 1'b1 || o_tx_data !== 8'h0A || to_cnt !== t0) begin
      errors++;
      $display("FAIL boundary_result: got st=%b tx=%h timeouts=%0d, want 1 0a 0",
               o_tx_start, o_tx_data, to_cnt - t0);
    end
    @(negedge i_clk);
    pulse_tx_done();
  endtask

  task automatic test_async_reset();
    send_byte(8'h05);
    send_byte(8'h03);
    #2 i_reset = 1'b1;
    #1;
    checks++;
    if (o_data_a !== 8'h00 || o_data_b !== 8'h00 || o_busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_cmd: got a=%h b=%h busy=%b, want 00 00 0", o_data_a, o_data_b, o_busy);
    end
    #1 i_reset = 1'b0;
    @(negedge i_clk);
    send_byte(8'h21);
    send_byte(8'h12);
    send_byte(8'h01);
    @(negedge i_clk);
    checks++;
    if (o_tx_start !== 1'b1 || o_tx_data !== 8'h33) begin
      errors++;
      $display("FAIL reset_recover1: got st=%b tx=%h, want 1 33", o_tx_start, o_tx_data);
    end
    @(negedge i_clk);       // now in WAIT_TX
    #2 i_reset = 1'b1;
    #1;
    checks++;
    if ({o_data_a, o_data_b, o_op, o_tx_data, o_tx_start, o_busy, o_timeout} !== 35'd0) begin
      errors++;
      $display("FAIL reset_wait_tx: got a=%h b=%h op=%h tx=%h st=%b busy=%b, want all 0",
               o_data_a, o_data_b, o_op, o_tx_data, o_tx_start, o_busy);
    end
    #1 i_reset = 1'b0;
    @(negedge i_clk);
    send_byte(8'h10);
    send_byte(8'h20);
    send_byte(8'h3F);
    @(negedge i_clk);
    checks++;
    if (o_tx_start !== 1'b1 || o_tx_data !== 8'h30 || o_op !== 6'h3F) begin
      errors++;
      $display("FAIL reset_recover2: got st=%b tx=%h op=%h, want 1 30 3f", o_tx_start, o_tx_data, o_op);
    end
    @(negedge i_clk);
    pulse_tx_done();
  endtask

  task automatic test_back_to_back();
    int s0, wait_cyc;
    logic [7:0] a, b, exp;
    s0 = start_cnt;
    for (int i = 0; i < 10; i++) begin
      a   = 8'(i * 17 + 3);
      b   = 8'(i * 29 + 250);
      exp = 8'((i * 17 + 3) + (i * 29 + 250));
      send_byte(a);
      send_byte(b);
      send_byte(8'(i));
      wait_cyc = 0;
      while (o_tx_start !== 1'b1 && wait_cyc < 5) begin
        @(negedge i_clk);
        wait_cyc++;
      end
      checks++;
      if (o_tx_start !== 1'b1 || o_tx_data !== exp) begin
        errors++;
        $display("FAIL b2b_cmd%0d: got st=%b tx=%h, want 1 %h", i, o_tx_start, o_tx_data, exp);
      end
      pulse_tx_done();
    end
    checks++;
    if (start_cnt - s0 !== 10) begin
      errors++;
      $display("FAIL b2b_pulse_count: got %0d, want 10", start_cnt - s0);
    end
    checks++;
    if (dbl_cnt !== 0) begin
      errors++;
      $display("FAIL single_cycle_pulses: got %0d multi-cycle pulses, want 0", dbl_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_drop_in_wait_tx();
    test_timeout();
    test_timeout_boundary();
    test_async_reset();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
